serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor. Computes num1 - num2 one bit per clock, LSB first, using a registered borrow.
- Area-lean counterpart to the combinational ripple-carry adder. Used where N-bit differences arrive rarely and gate count matters more than latency.
- Start/done handshake. The result format mirrors the adder: N-bit difference plus one extra bit, here the final borrow.

Parameters:
- N, 8, operand width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- num1  input  N  minuend; captured on the accepted start
- num2  input  N  subtrahend; captured on the accepted start
- ready  output  1  block can accept start (IDLE or DONE)
- done  output  1  one-cycle pulse: result valid
- result  output  N+1  [N-1:0] difference mod 2^N, [N] final borrow (1 iff num1 < num2 unsigned)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, ready=1, done=0, result=0, operand shift registers=0, borrow=0, bit counter=0.
- States:
  - IDLE: ready=1. start=1 captures num1/num2, clears borrow and counter, goes to RUN.
  - RUN: ready=0. Each cycle processes bit i = counter:
    - d = a_i ^ b_i ^ bin
    - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
    - d shifts into the result register from the MSB side; borrow <= bout; counter increments.
    - When counter = N-1, the final bit is written, result[N] <= bout, and the state goes to DONE.
  - DONE: done=1 for exactly this cycle; ready=1. start=1 here is accepted (back-to-back, same as the IDLE rule) and goes to RUN; otherwise the state goes to IDLE.
- Latency: start accepted at edge k; bits 0..N-1 are processed at edges k+1..k+N; done is high in the cycle after edge k+N. Throughput is one operation per N+1 cycles.
- result is written only at the final RUN edge. It holds its value through IDLE and through the next RUN until that operation finishes; it never shows a partial value.
- start while ready=0 is ignored. Operand changes during RUN have no effect.
- rst_n asserted mid-operation aborts at once to the reset values; no done pulse.
- Width rule: the difference is exact modulo 2^N. result[N] is the borrow, not a sign bit.

Optional Feature:
- Macro SERIAL_SUB_SIGNED_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is written together with result. It is 1 iff the signed two's-complement difference overflows: num1[N-1] != num2[N-1] and result[N-1] != num1[N-1].
  - Sign bits are captured at start.
- Undefined: no ovf port, no extra registers; behaviour otherwise identical.

Decomposition:
- Package serial_subtractor_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Function for counter width, $clog2(N).
- Sub-module full_subtractor (a, b, bin -> d, bout) is natural: one combinational cell, the mirror of the adder's FullAdder, instantiated once in the datapath.

Test Plan:
- N=8, start with 200,55 -> done after 9 cycles, result[7:0]=145, result[8]=0, ready=1 in the done cycle.
- 55,200 -> result[7:0]=111, result[8]=1; then 0,1 back-to-back via start in DONE -> 255, borrow 1, no idle gap.
- 0,0 and 255,255 -> result=0. Also check done is exactly one cycle and result is stable until the next completion.
- Pulse start again with different operands during RUN (cycle 4) -> ignored; original result delivered on schedule.
- Drop rst_n at cycle 5 of RUN -> outputs zero immediately, no done pulse. After release, 10,3 -> 7, borrow 0.
- With SERIAL_SUB_SIGNED_EN:
  - 0x80 - 0x01 -> 0x7F, ovf=1.
  - 0x7F - 0xFF -> 0x80, ovf=1.
  - 0x05 - 0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: num1 - num2 LSB first, one bit per clock, start/done handshake.
// Optional signed-overflow flag (port ovf) when SERIAL_SUB_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | processing one bit per cycle, ready=0
// DONE  | result valid, done pulse, ready=1 (back-to-back start allowed)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    output logic         ready,
    output logic         done,
    output logic [N:0]   result
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = cnt_width(N);

    state_t        state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic          borrow;
    logic [CW-1:0] cnt;
    logic          d;
    logic          bout;
    logic          last;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    assign last = (cnt == CW'(N - 1));

    // Difference bits shift into the top of a_sr as minuend bits leave the bottom,
    // so no separate accumulator is needed; result is only updated on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= num1;
                        b_sr   <= num2;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end else begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= {d, a_sr[N-1:1]};
                    b_sr   <= {1'b0, b_sr[N-1:1]};
                    borrow <= bout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        result <= {bout, d, a_sr[N-1:1]};
`ifdef SERIAL_SUB_SIGNED_EN
                        // On the last bit a_sr[0]/b_sr[0] still hold the captured sign bits.
                        ovf    <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`endif
                        done   <= 1'b1;
                        ready  <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences, random ops vs. arithmetic model.
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] num1;
    logic [N-1:0] num2;
    logic         ready;
    logic         done;
    logic [N:0]   result;
`ifdef SERIAL_SUB_SIGNED_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .num1   (num1),
        .num2   (num2),
        .ready  (ready),
        .done   (done),
        .result (result)
`ifdef SERIAL_SUB_SIGNED_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [N:0] model_res(input logic [N-1:0] a, input logic [N-1:0] b);
        int ai;
        int bi;
        int dm;
        ai = int'(a);
        bi = int'(b);
        dm = (ai - bi + (1 << N)) % (1 << N);
        return {(ai < bi) ? 1'b1 : 1'b0, N'(dm)};
    endfunction

    function automatic logic model_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
        int sd;
        sd = int'($signed(a)) - int'($signed(b));
        return (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
    endfunction

    // Called at a negedge with ready=1; returns at the negedge after the accepting edge.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        start = 1'b1;
        num1  = a;
        num2  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        num1  = N'($urandom);
        num2  = N'($urandom);
    endtask

    // Counts negedges until done; pulses start (with junk operands) at cycle pulse_at if nonzero.
    task automatic wait_done(input string name, input int pulse_at);
        int lat;
        lat = -1;
        for (int c = 1; c <= N + 6; c++) begin
            start = (c == pulse_at);
            if (c == pulse_at) begin
                num1 = N'($urandom);
                num2 = N'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(N));
    endtask

    task automatic check_done_cycle(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_ready"}, 32'(ready), 32'd1);
        check({name, "_result"}, 32'(result), 32'(model_res(a, b)));
`ifdef SERIAL_SUB_SIGNED_EN
        check({name, "_ovf"}, 32'(ovf), 32'(model_ovf(a, b)));
`endif
    endtask

    logic [N:0] held;

    initial begin
        vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0, 1'b0};
        vecs[1] = '{8'd55,  8'd200, 8'd111, 1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd1,   8'd255, 1'b1, 1'b0};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
        vecs[4] = '{8'd255, 8'd255, 8'd0,   1'b0, 1'b0};
        vecs[5] = '{8'd10,  8'd3,   8'd7,   1'b0, 1'b0};
        vecs[6] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[7] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
        vecs[8] = '{8'h05,  8'h03,  8'h02,  1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        num1  = '0;
        num2  = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, each from IDLE
        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b);
            check("run_ready_low", 32'(ready), 32'd0);
            wait_done("vec", 0);
            check("vec_result", 32'(result), 32'({vecs[i].borrow, vecs[i].diff}));
            check("vec_ready", 32'(ready), 32'd1);
`ifdef SERIAL_SUB_SIGNED_EN
            check("vec_ovf", 32'(ovf), 32'(vecs[i].ovf));
`endif
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
        end

        // Back-to-back: start accepted in the DONE cycle, no idle gap
        launch(8'd55, 8'd200);
        wait_done("b2b_first", 0);
        check_done_cycle("b2b_first", 8'd55, 8'd200);
        launch(8'd0, 8'd1);
        check("b2b_ready_low", 32'(ready), 32'd0);
        check("b2b_hold_prev", 32'(result), 32'(model_res(8'd55, 8'd200)));
        wait_done("b2b_second", 0);
        check_done_cycle("b2b_second", 8'd0, 8'd1);

        // done is one cycle; result holds through IDLE
        held = result;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_done_low", 32'(done), 32'd0);
            check("idle_result_hold", 32'(result), 32'(held));
        end

        // start pulsed during RUN cycle 4 is ignored
        launch(8'd200, 8'd55);
        wait_done("ignore_start", 4);
        check_done_cycle("ignore_start", 8'd200, 8'd55);
        @(negedge clk);
        check("ignore_back_idle", 32'(ready), 32'd1);

        // Reset mid-run aborts immediately with no done pulse
        launch(8'd123, 8'd45);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
`ifdef SERIAL_SUB_SIGNED_EN
        check("abort_ovf", 32'(ovf), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        launch(8'd10, 8'd3);
        wait_done("after_abort", 0);
        check_done_cycle("after_abort", 8'd10, 8'd3);
        @(negedge clk);

        // Random operations, occasionally back-to-back
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom);
            rb = N'($urandom);
            launch(ra, rb);
            wait_done("rand", 0);
            check_done_cycle("rand", ra, rb);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
